// File: rtl/bram_stream_reader.sv
// BRAM-port read master: fetches a block of consecutive words from a BRAM port
// and replays them in address order as an AXI4-Stream packet ending in TLAST.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WEN_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_STEP  = (DATA_WIDTH + 7) / 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] O_Addr,
    output logic                  O_EN,
    output logic [DATA_WIDTH-1:0] O_Din,
    input  logic [DATA_WIDTH-1:0] O_Dout,
    output logic [WEN_WIDTH-1:0]  O_WEN,
    output logic                  O_Clk,
    output logic                  O_Rst,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

    if (FIFO_DEPTH < 3) begin : g_depth_check
        $error("bram_stream_reader: FIFO_DEPTH must be at least 3");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  en_q;
    logic                  rd_vld_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  beats_q;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q;
    logic [PTR_W-1:0]      rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    logic                  push;
    logic                  pop;
    logic                  credit_ok;
    logic                  issue;
    logic                  last_issue;
    logic                  last_beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A read may only be launched if its word is guaranteed a buffer slot
    // when it lands two cycles later, counting words still in the BRAM pipe.
    always_comb begin
        push       = rd_vld_q;
        pop        = m_tvalid && m_tready;
        credit_ok  = (count_q + CNT_W'(en_q) + CNT_W'(rd_vld_q))
                     < (CNT_W'(FIFO_DEPTH) + CNT_W'(pop));
        issue      = (state_q == READ) && (issued_q != len_q) && credit_ok;
        last_issue = (issued_q == (len_q - LEN_WIDTH'(1)));
        last_beat  = pop && (beats_q == (len_q - LEN_WIDTH'(1)));
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            rd_vld_q <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            beats_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= en_q;
            if (pop) begin
                beats_q <= beats_q + LEN_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    en_q <= 1'b0;
                    if (start) begin
                        len_q   <= length;
                        beats_q <= '0;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q   <= 1'b1;
                            en_q     <= 1'b1;
                            addr_q   <= base_addr;
                            issued_q <= LEN_WIDTH'(1);
                            state_q  <= (length == LEN_WIDTH'(1)) ? DRAIN : READ;
                        end
                    end
                end
                READ: begin
                    en_q <= issue;
                    if (issue) begin
                        addr_q   <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                        issued_q <= issued_q + LEN_WIDTH'(1);
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    en_q <= 1'b0;
                    if (last_beat) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            count_q <= count_d;
        end
    end

    // Buffer storage carries no reset; tdata is masked whenever the buffer is empty.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wptr_q] <= O_Dout;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign O_Addr   = addr_q;
    assign O_EN     = en_q;
    assign O_Din    = '0;
    assign O_WEN    = '0;
    assign O_Clk    = Clk;
    assign O_Rst    = ~Rst_n;
    assign m_tvalid = (count_q != '0);
    assign m_tdata  = m_tvalid ? mem_q[rptr_q] : '0;
    assign m_tlast  = m_tvalid && (beats_q == (len_q - LEN_WIDTH'(1)));

endmodule
